// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences single-word loads and stores onto a data memory
// whose address is registered one cycle ahead of its data/enable. It accepts
// one request at a time, answers with a one-cycle response pulse, flags
// out-of-range addresses without touching memory, and keeps wrap-around
// load/store counters for debug.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. Request fields are sampled only at that edge.
// resp_valid is a single-cycle pulse that the consumer cannot stall.
module dmem_access_ctrl #(
  parameter int DSIZE = 16,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [DSIZE-1:0] req_addr,
  input  logic [DSIZE-1:0] req_wdata,
  output logic             resp_valid,
  output logic [DSIZE-1:0] resp_rdata,
  output logic             resp_err,
  output logic [DSIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_w_data,
  output logic             mem_write_en,
  output logic             mem_read_en,
  input  logic [DSIZE-1:0] mem_data_out,
  output logic [15:0]      load_cnt,
  output logic [15:0]      store_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // One extra bit so DEPTH itself is representable in the range compare.
  localparam logic [DSIZE:0] DEPTH_L = (DSIZE+1)'(DEPTH);

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [DSIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic [DSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [DSIZE-1:0] mem_w_data_q, mem_w_data_d;
  logic             mem_write_en_q, mem_write_en_d;
  logic             mem_read_en_q, mem_read_en_d;
  logic [15:0]      load_cnt_q, load_cnt_d;
  logic [15:0]      store_cnt_q, store_cnt_d;
  logic             addr_ok;

  assign addr_ok = ({1'b0, req_addr} < DEPTH_L);

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    req_ready_d    = 1'b0;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = '0;
    mem_addr_d     = mem_addr_q;
    mem_w_data_d   = '0;
    mem_write_en_d = 1'b0;
    mem_read_en_d  = 1'b0;
    load_cnt_d     = load_cnt_q;
    store_cnt_d    = store_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          we_d        = req_we;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (addr_ok) begin
            // Address goes out one cycle ahead of data/enable.
            state_d    = S_ADDR;
            mem_addr_d = req_addr;
          end else begin
            // Out-of-range: answer immediately, memory untouched.
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        state_d        = S_ACCESS;
        mem_write_en_d = we_q;
        mem_read_en_d  = ~we_q;
        mem_w_data_d   = we_q ? wdata_q : '0;
      end
      S_ACCESS: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = we_q ? '0 : mem_data_out;
        if (we_q) store_cnt_d = store_cnt_q + 16'd1;
        else      load_cnt_d  = load_cnt_q + 16'd1;
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_w_data_q   <= '0;
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      load_cnt_q     <= '0;
      store_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_w_data_q   <= mem_w_data_d;
      mem_write_en_q <= mem_write_en_d;
      mem_read_en_q  <= mem_read_en_d;
      load_cnt_q     <= load_cnt_d;
      store_cnt_q    <= store_cnt_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_addr     = mem_addr_q;
  assign mem_w_data   = mem_w_data_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_read_en  = mem_read_en_q;
  assign load_cnt     = load_cnt_q;
  assign store_cnt    = store_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: behavioural registered-address memory,
// table of request vectors, scoreboard queue of expected responses, and
// hand-written sequences for back-to-back, reset-abort and counter wrap.
module tb_dmem_access_ctrl;
  localparam int DSIZE = 16;
  localparam int DEPTH = 256;
  localparam int W     = DSIZE + 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we;
  logic [DSIZE-1:0] req_addr, req_wdata;
  logic             resp_valid, resp_err;
  logic [DSIZE-1:0] resp_rdata;
  logic [DSIZE-1:0] mem_addr, mem_w_data, mem_data_out;
  logic             mem_write_en, mem_read_en;
  logic [15:0]      load_cnt, store_cnt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_w_data(mem_w_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_data_out(mem_data_out),
    .load_cnt(load_cnt), .store_cnt(store_cnt), .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  logic [DSIZE-1:0] mem_model [DEPTH];
  logic [DSIZE-1:0] mem_addr_r;
  logic [7:0]       mem_idx;

  assign mem_idx      = mem_addr_r[7:0];
  assign mem_data_out = mem_read_en ? mem_model[mem_idx] : '0;

  always @(posedge clk) begin
    if (mem_write_en) mem_model[mem_idx] <= mem_w_data;
    mem_addr_r <= mem_addr;
  end

  // ---------------- scoreboard state ----------------
  int               n_cmp  = 0;
  int               n_fail = 0;
  int               cyc    = 0;
  int               we_cycles = 0;
  int               re_cycles = 0;
  logic [W-1:0]     exp_q[$];
  logic [DSIZE-1:0] ref_mem [DEPTH];
  logic [15:0]      exp_load_cnt, exp_store_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Count memory enable cycles and score every response against the queue.
  always @(negedge clk) begin
    if (mem_write_en) we_cycles++;
    if (mem_read_en)  re_cycles++;
    if (!rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("resp_err_rdata", {15'd0, resp_err, resp_rdata}, {15'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge with fields already driven; returns after the accepting posedge.
  task automatic wait_accept(output bit ok, output int acc_cyc);
    ok = 1'b0;
    acc_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready) begin
        acc_cyc = cyc;
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},     req_ready,    1);
    check({tag, "_rvalid"},    resp_valid,   0);
    check({tag, "_rerr"},      resp_err,     0);
    check({tag, "_rdata"},     resp_rdata,   0);
    check({tag, "_maddr"},     mem_addr,     0);
    check({tag, "_mwdata"},    mem_w_data,   0);
    check({tag, "_mwe"},       mem_write_en, 0);
    check({tag, "_mre"},       mem_read_en,  0);
    check({tag, "_load_cnt"},  load_cnt,     0);
    check({tag, "_store_cnt"}, store_cnt,    0);
    check({tag, "_state"},     dbg_state,    0);
  endtask

  // One isolated request: scoreboard push, latency, enable pulses, counters.
  task automatic do_req(input logic we, input logic [DSIZE-1:0] addr,
                        input logic [DSIZE-1:0] wdata, input logic exp_err,
                        input logic [DSIZE-1:0] exp_rdata, input string tag);
    bit ok;
    int acc, lat, we0, re0;
    logic [DSIZE-1:0] maddr0;
    we0 = we_cycles;
    re0 = re_cycles;
    maddr0 = mem_addr;
    req_we = we; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wait_accept(ok, acc);
    if (!ok) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      @(negedge clk);
      return;
    end
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    // Fields after acceptance must not matter.
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(0, 1));
    req_addr  = DSIZE'($urandom_range(0, 65535));
    req_wdata = DSIZE'($urandom_range(0, 65535));
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, exp_err ? 1 : 3);
    if (!exp_err) begin
      if (we) begin
        exp_store_cnt = exp_store_cnt + 16'd1;
        ref_mem[addr[7:0]] = wdata;
      end else begin
        exp_load_cnt = exp_load_cnt + 16'd1;
      end
    end else begin
      check({tag, "_maddr_held"}, mem_addr, maddr0);
    end
    check({tag, "_we_pulses"}, we_cycles - we0, (!exp_err && we) ? 1 : 0);
    check({tag, "_re_pulses"}, re_cycles - re0, (!exp_err && !we) ? 1 : 0);
    check({tag, "_load_cnt"},  load_cnt,  exp_load_cnt);
    check({tag, "_store_cnt"}, store_cnt, exp_store_cnt);
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             we;
    logic [DSIZE-1:0] addr;
    logic [DSIZE-1:0] wdata;
    logic             err;
    logic [DSIZE-1:0] rdata;
  } vec_t;

  vec_t vecs[12];

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    int acc_prev, acc_now, we0, waited;

    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = '0;
      ref_mem[i]   = '0;
    end
    mem_addr_r    = '0;
    exp_load_cnt  = '0;
    exp_store_cnt = '0;

    vecs[0]  = '{1'b1, 16'd5,      16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 16'd5,      16'h0000, 1'b0, 16'hBEEF};
    vecs[2]  = '{1'b1, 16'd255,    16'h1234, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 16'd255,    16'h0000, 1'b0, 16'h1234};
    vecs[4]  = '{1'b0, 16'd256,    16'h0000, 1'b1, 16'h0000};
    vecs[5]  = '{1'b1, 16'd300,    16'hAAAA, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 16'hFFFF,   16'h0000, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 16'd0,      16'h1111, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 16'd1,      16'h2222, 1'b0, 16'h0000};
    vecs[9]  = '{1'b0, 16'd0,      16'h0000, 1'b0, 16'h1111};
    vecs[10] = '{1'b0, 16'd1,      16'h0000, 1'b0, 16'h2222};
    vecs[11] = '{1'b0, 16'd2,      16'h0000, 1'b0, 16'h0000};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Table-driven single requests.
    for (int i = 0; i < 12; i++)
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].rdata,
             $sformatf("vec%0d", i));

    // Back-to-back stores with req_valid held high.
    we0 = we_cycles;
    acc_prev = 0;
    for (int i = 0; i < 4; i++) begin
      req_we = 1'b1; req_addr = DSIZE'(i); req_wdata = 16'hA000 + 16'(i); req_valid = 1'b1;
      wait_accept(ok, acc_now);
      if (!ok) begin
        check("b2b_accept_timeout", 32'd0, 32'd1);
        break;
      end
      exp_q.push_back({1'b0, 16'h0000});
      ref_mem[i] = 16'hA000 + 16'(i);
      exp_store_cnt = exp_store_cnt + 16'd1;
      if (i > 0) check("b2b_spacing", acc_now - acc_prev, 4);
      acc_prev = acc_now;
      @(negedge clk);
    end
    req_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_we_pulses", we_cycles - we0, 4);
    check("b2b_store_cnt", store_cnt, exp_store_cnt);
    for (int i = 0; i < 4; i++)
      do_req(1'b0, DSIZE'(i), '0, 1'b0, 16'hA000 + 16'(i), $sformatf("b2b_rd%0d", i));

    // Random mix around the low addresses and the top boundary.
    for (int i = 0; i < 16; i++) begin
      logic             we;
      logic [DSIZE-1:0] addr, wdata, rdata;
      logic             err;
      we    = 1'($urandom_range(0, 1));
      addr  = ($urandom_range(0, 1) == 1) ? DSIZE'($urandom_range(0, 7))
                                          : DSIZE'($urandom_range(250, 262));
      wdata = DSIZE'($urandom_range(0, 65535));
      err   = (addr >= DSIZE'(DEPTH));
      rdata = (err || we) ? '0 : ref_mem[addr[7:0]];
      do_req(we, addr, wdata, err, rdata, $sformatf("rnd%0d", i));
    end

    // Reset during ADDR of a store: the store must not reach memory.
    do_req(1'b1, 16'd7, 16'h1357, 1'b0, 16'h0000, "pre_rst");
    we0 = we_cycles;
    req_we = 1'b1; req_addr = 16'd7; req_wdata = 16'h5555; req_valid = 1'b1;
    wait_accept(ok, acc_now);
    check("rst_accept", ok, 1);
    @(negedge clk);
    check("rst_in_addr_state", dbg_state, 1);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    exp_load_cnt = '0; exp_store_cnt = '0;
    repeat (4) @(negedge clk);
    check("rst_no_write", we_cycles - we0, 0);
    check("rst_mem7", mem_model[7], 16'h1357);
    check("rst_ready", req_ready, 1);
    do_req(1'b0, 16'd7, '0, 1'b0, 16'h1357, "post_rst_rd");

    // Counter wrap: preload load_cnt to all ones, then one more load.
    force dut.load_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.load_cnt_q;
    @(negedge clk);
    exp_load_cnt = 16'hFFFF;
    check("wrap_preload", load_cnt, 16'hFFFF);
    do_req(1'b0, 16'd7, '0, 1'b0, 16'h1357, "wrap");
    check("wrap_zero", load_cnt, 16'h0000);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #500000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Data-memory access controller that initiates loads and stores on the single-port data-memory interface on behalf of the processor's memory stage. It accepts one request at a time from the pipeline over a valid/ready handshake and sequences the memory's registered-address protocol. It returns load data or store completion with a one-cycle response pulse, rejects out-of-range addresses, and keeps wrap-around load/store counters for debug.

## Interface
- DSIZE, 16, address and data width in bits
- DEPTH, 256, number of words in the data memory; valid addresses are 0..DEPTH-1
- clk  input  1  clock; all state updates on posedge
- rst  input  1  reset, synchronous, active-high
- req_valid  input  1  pipeline request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  DSIZE  word address
- req_wdata  input  DSIZE  store data
- resp_valid  output  1  one-cycle pulse: request complete
- resp_rdata  output  DSIZE  load data; 0 for stores and errors
- resp_err  output  1  valid with resp_valid: address out of range
- mem_addr  output  DSIZE  to memory addr
- mem_w_data  output  DSIZE  to memory w_data
- mem_write_en  output  1  to memory write_en
- mem_read_en  output  1  to memory read_en
- mem_data_out  input  DSIZE  from memory data_out
- load_cnt  output  16  completed successful loads, wraps at 65535->0
- store_cnt  output  16  completed successful stores, wraps at 65535->0

## Operation
- Memory protocol: the memory registers mem_addr on every posedge. mem_data_out reflects the registered address combinationally when mem_read_en=1. A write commits at a posedge to the registered address from the previous edge, using mem_w_data and mem_write_en from the current cycle. The address must therefore be presented one cycle before data/enable and held for that cycle.
- FSM states: IDLE, ADDR, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata into internal registers. If the address is in range (addr < DEPTH, unsigned), go to ADDR; otherwise go to RESP with the error flag set. With no req_valid, stay in IDLE.
- ADDR: mem_addr=latched addr; mem_write_en=0, mem_read_en=0. Always go to ACCESS.
- ACCESS: mem_addr held.
  - Store: mem_w_data=latched wdata, mem_write_en=1.
  - Load: mem_read_en=1; capture mem_data_out into resp_rdata at the ending edge.
  - Always go to RESP. Increment store_cnt or load_cnt at this edge.
- RESP: resp_valid=1, resp_err=error flag, resp_rdata=captured data (0 for store or error). req_ready=0. Always go to IDLE.
- Outside ACCESS: mem_write_en=0, mem_read_en=0, mem_w_data=0. mem_addr keeps its last driven value.
- Error requests never assert mem_read_en or mem_write_en and do not change the counters.
- Request fields are ignored except at the accepting edge in IDLE; changes afterwards have no effect on the in-flight access.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_w_data=0, mem_write_en=0, mem_read_en=0, load_cnt=0, store_cnt=0.
- Valid request accepted at edge E0: ADDR during cycle E0..E1, ACCESS during E1..E2, resp_valid high during E2..E3. Latency is 3 cycles from acceptance edge to resp_valid.
- Store data is in memory after edge E2.
- Error request accepted at E0: resp_valid/resp_err high during E0..E1; latency 1.
- Throughput: one valid request per 4 cycles; one error request per 2 cycles. req_ready is low in ADDR, ACCESS and RESP.
- resp_valid is a single-cycle pulse; the consumer cannot stall it.
- Reset mid-operation: rst=1 at any edge forces IDLE and the reset values at that edge. If rst is sampled during ACCESS, the controller still drives mem_write_en=1 in that cycle, so that store commits. No write is issued after the reset edge, and no response is generated for the aborted request.
- Counters increment only on ACCESS->RESP transitions.

## Test plan
- Store then load: store addr=5 data=16'hBEEF, then load addr=5 -> load resp_valid 3 cycles after acceptance, resp_rdata=16'hBEEF, resp_err=0; store_cnt=1, load_cnt=1.
- Back-to-back: req_valid held high with 4 stores to addresses 0..3 -> accepted every 4th cycle; mem_write_en high exactly one cycle per store; reading back gives the written data.
- Out of range: load addr=DEPTH (256) -> resp_valid next cycle, resp_err=1, resp_rdata=0; mem_read_en/mem_write_en never high; counters unchanged.
- Boundary: store/load at addr=DEPTH-1 (255) -> succeeds, resp_err=0, data round-trips.
- Reset mid-op: assert rst during ADDR of a store to addr=7 -> no mem_write_en pulse; memory[7] unchanged; all outputs at reset values the next cycle; req_ready=1.
- Counter wrap: preload via 65536 loads (or force) -> load_cnt wraps 65535->0 on the next completed load.
